candy_ifetch: RTL and testbench

Instruction-fetch responder on the consumer side of `candy_pc`. It samples the PC stream, issues reads to the instruction SRAM and buffers the returned words with their PC tags in a small FIFO for decode. It throttles `candy_pc` through `pc_enable`, so no address is issued unless its result is guaranteed a FIFO slot. Flush support lets branch redirects discard stale fetches.

---
 rtl/candy_ifetch_if.sv | 29 ++
 rtl/candy_ifetch.sv | 105 ++++++++++
 tb/tb_candy_ifetch.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/candy_ifetch_if.sv
// Fetch-side bus bundle: PC stream from candy_pc, SRAM read port and the
// instruction FIFO head presented to decode.
interface candy_ifetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc;
  logic              pc_enable;
  logic              sram_ce;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_rdata;
  logic              flush;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  // Environment side: PC source, SRAM and decode.
  modport master (
    output pc, sram_rdata, flush, inst_ready,
    input  pc_enable, sram_ce, sram_addr, inst_valid, inst, inst_pc
  );

  // Fetch unit side.
  modport slave (
    input  pc, sram_rdata, flush, inst_ready,
    output pc_enable, sram_ce, sram_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/candy_ifetch.sv
// Instruction fetch: issues SRAM reads for the PC stream only when the result
// is guaranteed a FIFO slot, tags returning words with their PC and buffers
// them for decode. Flush drops everything buffered or in flight.
module candy_ifetch #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SRAM_LAT = 1,
  parameter int DEPTH    = 4
) (
  input logic           clk,
  input logic           rst,
  candy_ifetch_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(SRAM_LAT + 1);
  localparam int OW = CW + 1;

  logic [DATA_W-1:0]   fifo_data [DEPTH];
  logic [ADDR_W-1:0]   fifo_pc   [DEPTH];
  logic [PW-1:0]       rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
  logic [CW-1:0]       count_reg, count_next, remain;
  logic [IW-1:0]       inflight_reg, inflight_next;
  logic [OW-1:0]       occupancy;
  logic [SRAM_LAT-1:0] sr_valid_reg, sr_valid_next;
  logic [ADDR_W-1:0]   sr_tag_reg  [SRAM_LAT];
  logic [ADDR_W-1:0]   sr_tag_next [SRAM_LAT];
  logic [DATA_W-1:0]   inst_reg;
  logic [ADDR_W-1:0]   inst_pc_reg;
  logic                issue, arrive, push, pop;

  // Credit check counts in-flight reads so every issue owns a FIFO slot.
  // Pop credit is deliberately not bypassed: it shows up a cycle later.
  assign occupancy     = OW'(count_reg) + OW'(inflight_reg);
  assign issue         = !rst && !bus.flush && (occupancy < OW'(DEPTH));
  assign bus.pc_enable = issue;
  assign bus.sram_ce   = issue;
  assign bus.sram_addr = bus.pc;

  assign arrive         = sr_valid_reg[SRAM_LAT-1];
  assign push           = arrive && !bus.flush;
  assign bus.inst_valid = !rst && (count_reg != '0);
  assign pop            = bus.inst_valid && bus.inst_ready && !bus.flush;
  assign bus.inst       = rst ? '0 : inst_reg;
  assign bus.inst_pc    = rst ? '0 : inst_pc_reg;

  assign rd_ptr_next   = rd_ptr_reg + PW'(pop);
  assign remain        = count_reg - CW'(pop);
  assign count_next    = remain + CW'(push);
  assign inflight_next = inflight_reg + IW'(issue) - IW'(arrive);

  // Latency pipe: stage 0 captures the issue, later stages just shift.
  assign sr_valid_next[0] = issue;
  assign sr_tag_next[0]   = bus.pc;
  for (genvar gi = 1; gi < SRAM_LAT; gi++) begin : g_stage
    assign sr_valid_next[gi] = sr_valid_reg[gi-1];
    assign sr_tag_next[gi]   = sr_tag_reg[gi-1];
  end

  // Advance the latency pipe; flush/reset kill every outstanding read.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) sr_valid_reg <= '0;
    else                  sr_valid_reg <= sr_valid_next;
    sr_tag_reg <= sr_tag_next;
  end

  // FIFO storage write; contents need no reset since count gates them.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_data[wr_ptr_reg] <= bus.sram_rdata;
      fifo_pc[wr_ptr_reg]   <= sr_tag_reg[SRAM_LAT-1];
    end
  end

  // Pointers, counters and the registered head presented to decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= '0;
      inst_reg     <= '0;
      inst_pc_reg  <= '0;
    end else if (bus.flush) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      inflight_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      inflight_reg <= inflight_next;
      // Head after this edge: either an older entry, or the word landing now
      // when the FIFO would otherwise be empty; hold when nothing is left.
      if (remain != '0) begin
        inst_reg    <= fifo_data[rd_ptr_next];
        inst_pc_reg <= fifo_pc[rd_ptr_next];
      end else if (push) begin
        inst_reg    <= bus.sram_rdata;
        inst_pc_reg <= sr_tag_reg[SRAM_LAT-1];
      end
    end
  end
endmodule

// File: tb/tb_candy_ifetch.sv
// Directed bench for candy_ifetch (DEPTH=4, SRAM_LAT=1): reset, backpressure,
// push+pop at full credit, streaming, flush redirect and mid-run reset.
module tb_candy_ifetch;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic        clk;
  logic        rst;
  logic [31:0] pc_q     = '0;
  logic [31:0] rdata_q  = '0;
  logic [31:0] redirect = '0;
  logic [31:0] exp_pc;
  logic [31:0] cur_pc;
  int          total = 0;
  int          bad   = 0;

  candy_ifetch_if bus ();

  candy_ifetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.pc         = pc_q;
  assign bus.sram_rdata = rdata_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // candy_pc model: advance on pc_enable, load the redirect target on flush.
  always @(posedge clk) begin
    if (bus.flush)          pc_q <= redirect;
    else if (bus.pc_enable) pc_q <= pc_q + 32'd4;
  end

  // One-cycle SRAM with mem[a] = a ^ KEY.
  always @(posedge clk) begin
    rdata_q <= bus.sram_ce ? (bus.sram_addr ^ KEY) : 32'hDEADBEEF;
  end

  // A word must never land in a full FIFO unless a pop frees a slot.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      assert (!(dut.count_reg == 3'd4 && dut.push && !dut.pop))
      else begin
        bad++;
        $error("FAIL push_on_full obs=1 exp=0");
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.flush      = 1'b0;
    bus.inst_ready = 1'b0;

    // Reset held for three cycles.
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_pc_enable", 64'(bus.pc_enable), 64'd0);
      chk("rst_sram_ce", 64'(bus.sram_ce), 64'd0);
      chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
      chk("rst_inst", 64'(bus.inst), 64'd0);
      chk("rst_inst_pc", 64'(bus.inst_pc), 64'd0);
    end

    // Release with inst_ready=0: four issues 0x0..0xC, first word after 2 cycles.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) rst = 1'b0;
      #1;
      chk("bp_pc_enable", 64'(bus.pc_enable), 64'd1);
      chk("bp_sram_addr", 64'(bus.sram_addr), 64'(32'(4 * k)));
      chk("bp_inst_valid", 64'(bus.inst_valid), 64'(k >= 2));
      $display("issue addr=%08h", bus.sram_addr);
    end

    // Credit exhausted (3 buffered + 1 in flight): pc holds at 0x10.
    // Pulse inst_ready: pop 0x0 and the landing 0xC coincide.
    @(negedge clk);
    bus.inst_ready = 1'b1;
    #1;
    chk("full_pc_enable", 64'(bus.pc_enable), 64'd0);
    chk("full_pc_hold", 64'(pc_q), 64'h10);
    chk("full_inst_valid", 64'(bus.inst_valid), 64'd1);
    chk("full_head_pc", 64'(bus.inst_pc), 64'h0);
    chk("full_head_inst", 64'(bus.inst), 64'(KEY));
    chk("full_count", 64'(dut.count_reg), 64'd3);

    @(negedge clk);
    bus.inst_ready = 1'b0;
    #1;
    chk("pp_count_kept", 64'(dut.count_reg), 64'd3);
    chk("pp_pc_enable", 64'(bus.pc_enable), 64'd1);
    chk("pp_resume_addr", 64'(bus.sram_addr), 64'h10);
    chk("pp_head_pc", 64'(bus.inst_pc), 64'h4);

    @(negedge clk); #1;
    chk("pp2_pc_enable", 64'(bus.pc_enable), 64'd0);

    @(negedge clk);
    bus.inst_ready = 1'b1;
    #1;
    chk("max_count", 64'(dut.count_reg), 64'd4);
    chk("max_pc_enable", 64'(bus.pc_enable), 64'd0);

    // Streaming: one instruction per cycle, PCs consecutive from 0x4.
    exp_pc = 32'h4;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) begin
        @(negedge clk); #1;
      end
      chk("st_inst_valid", 64'(bus.inst_valid), 64'd1);
      chk("st_inst_pc", 64'(bus.inst_pc), 64'(exp_pc));
      chk("st_inst", 64'(bus.inst), 64'(exp_pc ^ KEY));
      $display("pop pc=%08h inst=%08h", bus.inst_pc, bus.inst);
      exp_pc = exp_pc + 32'd4;
    end

    // Flush with redirect to 0x100 while words are buffered and in flight.
    @(negedge clk);
    bus.flush = 1'b1;
    redirect  = 32'h100;
    #1;
    chk("fl_pc_enable", 64'(bus.pc_enable), 64'd0);
    chk("fl_sram_ce", 64'(bus.sram_ce), 64'd0);

    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("fl_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("fl_count", 64'(dut.count_reg), 64'd0);
    chk("fl_pc_enable_after", 64'(bus.pc_enable), 64'd1);
    chk("fl_sram_addr", 64'(bus.sram_addr), 64'h100);

    @(negedge clk); #1;
    chk("fl_gap_valid", 64'(bus.inst_valid), 64'd0);

    @(negedge clk); #1;
    chk("fl_first_valid", 64'(bus.inst_valid), 64'd1);
    chk("fl_first_pc", 64'(bus.inst_pc), 64'h100);
    chk("fl_first_inst", 64'(bus.inst), 64'(32'h100 ^ KEY));
    $display("pop pc=%08h inst=%08h", bus.inst_pc, bus.inst);

    @(negedge clk); #1;
    chk("fl_second_pc", 64'(bus.inst_pc), 64'h104);
    chk("fl_second_inst", 64'(bus.inst), 64'(32'h104 ^ KEY));
    $display("pop pc=%08h inst=%08h", bus.inst_pc, bus.inst);

    // Fill the FIFO, then reset for one cycle with inst_ready high.
    @(negedge clk);
    bus.inst_ready = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("fill_count", 64'(dut.count_reg), 64'd4);
    chk("fill_pc_enable", 64'(bus.pc_enable), 64'd0);

    @(negedge clk);
    rst            = 1'b1;
    bus.inst_ready = 1'b1;
    #1;
    cur_pc = pc_q;
    chk("mr_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("mr_pc_enable", 64'(bus.pc_enable), 64'd0);
    chk("mr_sram_ce", 64'(bus.sram_ce), 64'd0);
    chk("mr_inst", 64'(bus.inst), 64'd0);
    chk("mr_inst_pc", 64'(bus.inst_pc), 64'd0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_count", 64'(dut.count_reg), 64'd0);
    chk("mr_valid_after", 64'(bus.inst_valid), 64'd0);
    chk("mr_restart_en", 64'(bus.pc_enable), 64'd1);
    chk("mr_restart_addr", 64'(bus.sram_addr), 64'(cur_pc));

    @(negedge clk);
    @(negedge clk); #1;
    chk("mr_first_valid", 64'(bus.inst_valid), 64'd1);
    chk("mr_first_pc", 64'(bus.inst_pc), 64'(cur_pc));
    chk("mr_first_inst", 64'(bus.inst), 64'(cur_pc ^ KEY));
    $display("pop pc=%08h inst=%08h", bus.inst_pc, bus.inst);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
